// File: rtl/data_mem_responder_if.sv
// rtl/data_mem_responder_if.sv - CPU load/store bus between the MIPS core and its data memory
interface data_mem_responder_if;
  logic        MemWrite;
  logic        MemtoReg;
  logic [31:0] Addr;
  logic [31:0] WriteData;
  logic [31:0] AluResult;
  logic [31:0] DataToWd;
  logic        Ready;
  logic        Fault;
  logic [31:0] FaultAddr;
  logic [15:0] StoreCount;

  modport master (
    output MemWrite, MemtoReg, Addr, WriteData, AluResult,
    input  DataToWd, Ready, Fault, FaultAddr, StoreCount
  );

  modport slave (
    input  MemWrite, MemtoReg, Addr, WriteData, AluResult,
    output DataToWd, Ready, Fault, FaultAddr, StoreCount
  );
endinterface

// File: rtl/data_mem_responder.sv
// rtl/data_mem_responder.sv - data memory with post-reset clear sweep, combinational loads and sticky access-fault trap
module data_mem_responder #(
  parameter int          ADDR_WIDTH = 6,
  parameter logic [31:0] BASE_ADDR  = 32'h0000_0000
) (
  input  logic Clock,
  input  logic Reset,
  data_mem_responder_if.slave bus
);
  localparam int                    DEPTH    = 2 ** ADDR_WIDTH;
  localparam logic [31:0]           SPAN     = 32'(4 * DEPTH);
  localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(DEPTH - 1);

  typedef enum logic [1:0] {CLEAR, RUN, HALT} state_t;

  state_t                state, state_nxt;
  logic [ADDR_WIDTH-1:0] clr_idx;
  logic [ADDR_WIDTH-1:0] idx;
  logic [31:0]           mem [DEPTH];
  logic [31:0]           offset;
  logic [31:0]           rd_data;
  logic [31:0]           data_out;
  logic                  valid;
  logic                  access;
  logic                  fault_now;
  logic                  do_store;
  logic                  fault_q;
  logic [31:0]           fault_addr_q;
  logic [15:0]           store_count_q;

  assign offset  = bus.Addr - BASE_ADDR;
  assign idx     = offset[ADDR_WIDTH+1:2];
  assign valid   = (bus.Addr[1:0] == 2'b00) && (offset < SPAN);
  assign access  = bus.MemWrite | bus.MemtoReg;
  assign rd_data = mem[idx];

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state <= CLEAR;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    fault_now = 1'b0;
    do_store  = 1'b0;
    data_out  = bus.MemtoReg ? 32'd0 : bus.AluResult;
    case (state)
      CLEAR: begin
        if (clr_idx == LAST_IDX) state_nxt = RUN;
      end
      RUN: begin
        fault_now = (access && !valid) || (bus.MemWrite && bus.MemtoReg);
        if (fault_now) begin
          data_out  = 32'd0;
          state_nxt = HALT;
        end else begin
          do_store = bus.MemWrite;
          if (bus.MemtoReg) data_out = rd_data;
        end
      end
      HALT: begin
        state_nxt = HALT;
      end
      default: state_nxt = CLEAR;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      clr_idx       <= '0;
      fault_q       <= 1'b0;
      fault_addr_q  <= 32'd0;
      store_count_q <= 16'd0;
    end else begin
      if (state == CLEAR) clr_idx <= clr_idx + 1'b1;
      if (fault_now) begin
        fault_q      <= 1'b1;
        fault_addr_q <= bus.Addr;
      end
      if (do_store) store_count_q <= store_count_q + 16'd1;
    end
  end

  // RAM has no reset; contents are only zeroed by the CLEAR sweep.
  always_ff @(posedge Clock) begin
    if (!Reset) begin
      if (state == CLEAR) mem[clr_idx] <= 32'd0;
      else if (do_store)  mem[idx]     <= bus.WriteData;
    end
  end

  assign bus.DataToWd   = data_out;
  assign bus.Ready      = (state == RUN);
  assign bus.Fault      = fault_q;
  assign bus.FaultAddr  = fault_addr_q;
  assign bus.StoreCount = store_count_q;
endmodule

// File: tb/tb_data_mem_responder.sv
// tb/tb_data_mem_responder.sv - randomized self-checking bench for data_mem_responder
module tb_data_mem_responder;
  localparam int M_CLEAR = 0;
  localparam int M_RUN   = 1;
  localparam int M_HALT  = 2;

  logic Clock = 1'b0;
  logic Reset = 1'b1;
  int   errors = 0;
  int   checks = 0;

  logic [31:0] m_mem [64];
  int          m_state = M_CLEAR;
  int          m_clr = 0;
  logic        m_fault = 1'b0;
  logic [31:0] m_faddr = 32'd0;
  logic [15:0] m_count = 16'd0;

  data_mem_responder_if bus();

  data_mem_responder #(.ADDR_WIDTH(6), .BASE_ADDR(32'h0000_0000)) dut (
    .Clock(Clock),
    .Reset(Reset),
    .bus(bus)
  );

  always #5 Clock = ~Clock;

  function automatic logic m_valid(input logic [31:0] a);
    return (a[1:0] == 2'b00) && (a < 32'd256);
  endfunction

  function automatic logic m_fault_cond();
    return ((bus.MemWrite || bus.MemtoReg) && !m_valid(bus.Addr)) || (bus.MemWrite && bus.MemtoReg);
  endfunction

  function automatic logic [31:0] m_data();
    if (m_state != M_RUN) return bus.MemtoReg ? 32'd0 : bus.AluResult;
    if (m_fault_cond()) return 32'd0;
    return bus.MemtoReg ? m_mem[bus.Addr[7:2]] : bus.AluResult;
  endfunction

  task automatic drive(input logic mw, input logic mr, input logic [31:0] a,
                       input logic [31:0] wd, input logic [31:0] alu);
    bus.MemWrite  = mw;
    bus.MemtoReg  = mr;
    bus.Addr      = a;
    bus.WriteData = wd;
    bus.AluResult = alu;
    #1;
  endtask

  task automatic step();
    @(posedge Clock);
    if (Reset) begin
      m_state = M_CLEAR; m_clr = 0; m_fault = 1'b0; m_faddr = 32'd0; m_count = 16'd0;
    end else begin
      case (m_state)
        M_CLEAR: begin
          m_mem[m_clr] = 32'd0;
          if (m_clr == 63) m_state = M_RUN;
          m_clr = (m_clr + 1) % 64;
        end
        M_RUN: begin
          if (m_fault_cond()) begin
            m_fault = 1'b1; m_faddr = bus.Addr; m_state = M_HALT;
          end else if (bus.MemWrite) begin
            m_mem[bus.Addr[7:2]] = bus.WriteData;
            m_count = m_count + 16'd1;
          end
        end
        default: ;
      endcase
    end
    #1;
  endtask

  task automatic reset_and_clear();
    int n;
    Reset = 1'b1;
    drive(1'b0, 1'b0, 32'd0, 32'd0, 32'd0);
    step();
    Reset = 1'b0;
    n = 0;
    while (bus.Ready !== 1'b1 && n < 200) begin
      step();
      n++;
    end
    checks++;
    if (n != 64) begin
      errors++;
      $display("FAIL clear_edges: got %0d edges, expected 64", n);
    end
  endtask

  task automatic test_reset();
    logic mr;
    logic [31:0] alu;
    Reset = 1'b1;
    drive(1'b0, 1'b0, 32'd0, 32'd0, 32'd0);
    step();
    Reset = 1'b0;
    checks += 4;
    if (bus.Ready !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b expected 0", bus.Ready); end
    if (bus.Fault !== 1'b0) begin errors++; $display("FAIL reset_fault: got %b expected 0", bus.Fault); end
    if (bus.FaultAddr !== 32'd0) begin errors++; $display("FAIL reset_faultaddr: got %h expected 0", bus.FaultAddr); end
    if (bus.StoreCount !== 16'd0) begin errors++; $display("FAIL reset_count: got %0d expected 0", bus.StoreCount); end
    for (int i = 1; i <= 64; i++) begin
      mr  = 1'($urandom_range(0, 1));
      alu = $urandom;
      drive(1'($urandom_range(0, 1)), mr, $urandom_range(0, 511), $urandom, alu);
      checks++;
      if (bus.DataToWd !== (mr ? 32'd0 : alu)) begin
        errors++; $display("FAIL clear_data: edge %0d got %h expected %h", i, bus.DataToWd, mr ? 32'd0 : alu);
      end
      step();
      checks++;
      if (bus.Ready !== (i == 64)) begin
        errors++; $display("FAIL clear_ready: edge %0d got %b expected %b", i, bus.Ready, i == 64);
      end
    end
    checks += 2;
    if (bus.Fault !== 1'b0) begin errors++; $display("FAIL clear_no_fault: got %b expected 0", bus.Fault); end
    if (bus.StoreCount !== 16'd0) begin errors++; $display("FAIL clear_no_store: got %0d expected 0", bus.StoreCount); end
    for (int a = 0; a < 256; a += 4) begin
      drive(1'b0, 1'b1, 32'(a), 32'd0, $urandom);
      checks++;
      if (bus.DataToWd !== 32'd0) begin errors++; $display("FAIL zero_fill: addr %h got %h expected 0", a, bus.DataToWd); end
      step();
    end
  endtask

  task automatic test_store_load();
    drive(1'b1, 1'b0, 32'h10, 32'hDEAD_BEEF, 32'h10);
    step();
    drive(1'b0, 1'b1, 32'h10, 32'd0, 32'h55);
    checks += 2;
    if (bus.DataToWd !== 32'hDEAD_BEEF) begin errors++; $display("FAIL store_load: got %h expected deadbeef", bus.DataToWd); end
    if (bus.StoreCount !== 16'd1) begin errors++; $display("FAIL store_count: got %0d expected 1", bus.StoreCount); end
    step();
  endtask

  task automatic test_read_after_write();
    drive(1'b0, 1'b1, 32'h20, 32'd0, 32'h77);
    checks++;
    if (bus.DataToWd !== 32'd0) begin errors++; $display("FAIL raw_before: got %h expected 0", bus.DataToWd); end
    step();
    drive(1'b1, 1'b0, 32'h20, 32'h1, 32'h99);
    checks++;
    if (bus.DataToWd !== 32'h99) begin errors++; $display("FAIL raw_store_cycle: got %h expected 99", bus.DataToWd); end
    step();
    drive(1'b0, 1'b1, 32'h20, 32'd0, 32'h77);
    checks++;
    if (bus.DataToWd !== 32'h1) begin errors++; $display("FAIL raw_after: got %h expected 1", bus.DataToWd); end
    step();
  endtask

  task automatic test_random_traffic();
    int op;
    logic [31:0] exp;
    for (int i = 0; i < 400; i++) begin
      op = $urandom_range(0, 2);
      drive(op == 1, op == 2, 32'($urandom_range(0, 15)) * 4, $urandom, $urandom);
      exp = m_data();
      checks++;
      if (bus.DataToWd !== exp) begin errors++; $display("FAIL rand_data: cycle %0d got %h expected %h", i, bus.DataToWd, exp); end
      step();
      checks += 2;
      if (bus.StoreCount !== m_count) begin errors++; $display("FAIL rand_count: got %0d expected %0d", bus.StoreCount, m_count); end
      if (bus.Ready !== 1'b1) begin errors++; $display("FAIL rand_ready: got %b expected 1", bus.Ready); end
    end
  endtask

  task automatic test_fault_misaligned();
    logic [15:0] cnt;
    cnt = m_count;
    drive(1'b0, 1'b1, 32'h13, 32'd0, 32'h1234);
    checks++;
    if (bus.DataToWd !== 32'd0) begin errors++; $display("FAIL mis_data: got %h expected 0", bus.DataToWd); end
    step();
    checks += 3;
    if (bus.Fault !== 1'b1) begin errors++; $display("FAIL mis_fault: got %b expected 1", bus.Fault); end
    if (bus.FaultAddr !== 32'h13) begin errors++; $display("FAIL mis_faultaddr: got %h expected 13", bus.FaultAddr); end
    if (bus.Ready !== 1'b0) begin errors++; $display("FAIL mis_ready: got %b expected 0", bus.Ready); end
    drive(1'b1, 1'b0, 32'h10, 32'hCAFE_F00D, 32'hABCD);
    checks++;
    if (bus.DataToWd !== 32'hABCD) begin errors++; $display("FAIL halt_alu: got %h expected abcd", bus.DataToWd); end
    step();
    drive(1'b0, 1'b1, 32'h10, 32'd0, 32'hABCD);
    checks += 4;
    if (bus.DataToWd !== 32'd0) begin errors++; $display("FAIL halt_load: got %h expected 0", bus.DataToWd); end
    if (bus.StoreCount !== cnt) begin errors++; $display("FAIL halt_count: got %0d expected %0d", bus.StoreCount, cnt); end
    if (bus.Fault !== 1'b1) begin errors++; $display("FAIL halt_fault_hold: got %b expected 1", bus.Fault); end
    if (bus.FaultAddr !== 32'h13) begin errors++; $display("FAIL halt_faultaddr_hold: got %h expected 13", bus.FaultAddr); end
    step();
    reset_and_clear();
    drive(1'b0, 1'b1, 32'h10, 32'd0, 32'h5);
    checks += 2;
    if (bus.DataToWd !== 32'd0) begin errors++; $display("FAIL mis_cleared: got %h expected 0", bus.DataToWd); end
    if (bus.Fault !== 1'b0) begin errors++; $display("FAIL mis_fault_reset: got %b expected 0", bus.Fault); end
    step();
  endtask

  task automatic test_fault_range();
    drive(1'b1, 1'b0, 32'hFC, 32'h55, 32'h0);
    step();
    drive(1'b1, 1'b0, 32'h100, 32'hBAD0_BAD0, 32'h42);
    checks++;
    if (bus.DataToWd !== 32'd0) begin errors++; $display("FAIL range_data: got %h expected 0", bus.DataToWd); end
    step();
    checks += 3;
    if (bus.Fault !== 1'b1) begin errors++; $display("FAIL range_fault: got %b expected 1", bus.Fault); end
    if (bus.FaultAddr !== 32'h100) begin errors++; $display("FAIL range_faultaddr: got %h expected 100", bus.FaultAddr); end
    if (bus.StoreCount !== 16'd1) begin errors++; $display("FAIL range_count: got %0d expected 1", bus.StoreCount); end
    reset_and_clear();
    drive(1'b1, 1'b1, 32'h8, 32'h3, 32'h9);
    checks++;
    if (bus.DataToWd !== 32'd0) begin errors++; $display("FAIL both_data: got %h expected 0", bus.DataToWd); end
    step();
    checks += 3;
    if (bus.Fault !== 1'b1) begin errors++; $display("FAIL both_fault: got %b expected 1", bus.Fault); end
    if (bus.FaultAddr !== 32'h8) begin errors++; $display("FAIL both_faultaddr: got %h expected 8", bus.FaultAddr); end
    if (bus.StoreCount !== 16'd0) begin errors++; $display("FAIL both_count: got %0d expected 0", bus.StoreCount); end
  endtask

  task automatic test_count_wrap();
    reset_and_clear();
    for (int i = 0; i < 65535; i++) begin
      drive(1'b1, 1'b0, 32'h0, 32'(i), 32'h0);
      step();
    end
    checks++;
    if (bus.StoreCount !== 16'hFFFF) begin errors++; $display("FAIL count_ffff: got %h expected ffff", bus.StoreCount); end
    drive(1'b1, 1'b0, 32'h0, 32'h0001_0000, 32'h0);
    step();
    drive(1'b0, 1'b1, 32'h0, 32'd0, 32'h0);
    checks += 2;
    if (bus.StoreCount !== 16'd0) begin errors++; $display("FAIL count_wrap: got %h expected 0", bus.StoreCount); end
    if (bus.DataToWd !== 32'h0001_0000) begin errors++; $display("FAIL wrap_last: got %h expected 00010000", bus.DataToWd); end
    step();
  endtask

  task automatic test_reset_mid_clear();
    Reset = 1'b1;
    drive(1'b0, 1'b0, 32'd0, 32'd0, 32'd0);
    step();
    Reset = 1'b0;
    for (int i = 0; i < 30; i++) step();
    checks++;
    if (bus.Ready !== 1'b0) begin errors++; $display("FAIL mid_clear_ready: got %b expected 0", bus.Ready); end
    reset_and_clear();
    drive(1'b0, 1'b1, 32'h0, 32'd0, 32'h0);
    checks++;
    if (bus.DataToWd !== 32'd0) begin errors++; $display("FAIL mid_clear_zero: got %h expected 0", bus.DataToWd); end
    step();
  endtask

  initial begin
    test_reset();
    test_store_load();
    test_read_after_write();
    test_random_traffic();
    test_fault_misaligned();
    test_fault_range();
    test_count_wrap();
    test_reset_mid_clear();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
